// File: rtl/fir_sched_pkg.sv
// Shared types and helpers for the FIR channel scheduler.
package fir_sched_pkg;

    localparam int SAMPLE_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        BUSY,
        CAPTURE,
        DELIVER
    } sched_state_t;

    function automatic int ch_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fir_channel_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping.
// With FIR_SCHED_PRIORITY_EN, channel 0 overrides and rotation covers 1..N_CH-1 only.
module rr_arbiter
    import fir_sched_pkg::*;
#(
    parameter int N_CH = 4,
    localparam int CW  = ch_width(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CW-1:0]   ptr,
    output logic [N_CH-1:0] gnt,
    output logic [CW-1:0]   gnt_idx,
    output logic            any_req
);
    logic [N_CH-1:0] rr_req;
    logic [CW:0]     idx;

    // NOTE: every output gets a default before the loop, so no path infers a latch.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        idx     = '0;
        any_req = |req;
        rr_req  = req;
`ifdef FIR_SCHED_PRIORITY_EN
        rr_req[0] = 1'b0;
`endif
        // Scan from the farthest offset back to ptr so the nearest requester wins.
        for (int i = N_CH - 1; i >= 0; i--) begin
            idx = {1'b0, ptr} + (CW + 1)'(i);
            if (idx >= (CW + 1)'(N_CH)) begin
                idx = idx - (CW + 1)'(N_CH);
            end
            if (rr_req[idx[CW-1:0]]) begin
                gnt_idx = idx[CW-1:0];
            end
        end
`ifdef FIR_SCHED_PRIORITY_EN
        if (req[0]) begin
            gnt_idx = '0;
        end
`endif
        if (any_req) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/fir_channel_scheduler.sv
// Time-shares one serial FIR engine between N_CH producers, one transaction in flight.
// Optional macro FIR_SCHED_PRIORITY_EN makes channel 0 strict high priority.
module fir_channel_scheduler
    import fir_sched_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int W       = SAMPLE_W,
    parameter int TIMEOUT = 63,
    localparam int CW     = ch_width(N_CH)
) (
    input  logic              ck,
    input  logic              rst,
    input  logic [N_CH-1:0]   req_valid,
    input  logic [N_CH*W-1:0] req_data,
    output logic [N_CH-1:0]   req_ack,
    output logic [W-1:0]      eng_in,
    output logic              eng_input_ready,
    output logic [CW-1:0]     eng_ch,
    input  logic [W-1:0]      eng_out,
    input  logic              eng_output_ready,
    output logic [W-1:0]      res_data,
    output logic [CW-1:0]     res_ch,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              err,
    output logic [CW-1:0]     err_ch
);
    localparam int TW = $clog2(TIMEOUT + 1);

    sched_state_t    state, state_next;
    logic [CW-1:0]   ptr, ch_q, ch_after, gnt_idx;
    logic [W-1:0]    sample_q;
    logic [TW-1:0]   timer, timer_inc;
    logic [N_CH-1:0] gnt;
    logic            any_req, timeout_hit, release_ch;

    rr_arbiter #(.N_CH(N_CH)) u_arb (
        .req     (req_valid),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any_req (any_req)
    );

    assign timer_inc = timer + 1'b1;
    assign ch_after  = (ch_q == CW'(N_CH - 1)) ? '0 : ch_q + 1'b1;
    assign eng_in    = sample_q;
    assign eng_ch    = ch_q;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge ck) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next      = state;
        req_ack         = '0;
        eng_input_ready = 1'b0;
        res_valid       = 1'b0;
        timeout_hit     = 1'b0;
        release_ch      = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    req_ack    = gnt;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                eng_input_ready = 1'b1;
                state_next      = BUSY;
            end
            BUSY: begin
                if (eng_output_ready) begin
                    state_next = CAPTURE;
                end else if (timer_inc == TW'(TIMEOUT)) begin
                    timeout_hit = 1'b1;
                    release_ch  = 1'b1;
                    state_next  = IDLE;
                end
            end
            CAPTURE: state_next = DELIVER;
            DELIVER: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    release_ch = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            ptr      <= '0;
            ch_q     <= '0;
            sample_q <= '0;
            timer    <= '0;
            res_data <= '0;
            res_ch   <= '0;
            err      <= 1'b0;
            err_ch   <= '0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        sample_q <= req_data[gnt_idx*W +: W];
                        ch_q     <= gnt_idx;
                    end
                end
                ISSUE: timer <= '0;
                BUSY: begin
                    timer <= timer_inc;
                    if (timeout_hit) begin
                        err    <= 1'b1;
                        err_ch <= ch_q;
                    end
                end
                // The engine presents its result one cycle after the completion pulse.
                CAPTURE: begin
                    res_data <= eng_out;
                    res_ch   <= ch_q;
                end
                default: ;
            endcase
`ifdef FIR_SCHED_PRIORITY_EN
            if (release_ch && ch_q != '0) begin
                ptr <= ch_after;
            end
`else
            if (release_ch) begin
                ptr <= ch_after;
            end
`endif
        end
    end

endmodule

// File: tb/tb_fir_channel_scheduler.sv
// Scoreboard bench: random producers and engine model, checked against a channel-level model.
module tb_fir_channel_scheduler;
    localparam int N_CH = 4;
    localparam int W    = 16;
    localparam int CW   = 2;

    logic              ck = 1'b0;
    logic              rst;
    logic [N_CH-1:0]   req_valid;
    logic [N_CH*W-1:0] req_data;
    logic [N_CH-1:0]   req_ack;
    logic [W-1:0]      eng_in;
    logic              eng_input_ready;
    logic [CW-1:0]     eng_ch;
    logic [W-1:0]      eng_out;
    logic              eng_output_ready;
    logic [W-1:0]      res_data;
    logic [CW-1:0]     res_ch;
    logic              res_valid;
    logic              res_ready;
    logic              err;
    logic [CW-1:0]     err_ch;

    fir_channel_scheduler #(.N_CH(N_CH), .W(W), .TIMEOUT(63)) dut (
        .ck               (ck),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_data         (req_data),
        .req_ack          (req_ack),
        .eng_in           (eng_in),
        .eng_input_ready  (eng_input_ready),
        .eng_ch           (eng_ch),
        .eng_out          (eng_out),
        .eng_output_ready (eng_output_ready),
        .res_data         (res_data),
        .res_ch           (res_ch),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .err              (err),
        .err_ch           (err_ch)
    );

    always #5 ck = ~ck;

    typedef struct {
        bit is_err;
        int ch;
        int val;
    } exp_t;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   remaining[N_CH];
    int   data_m[N_CH];
    bit   ack_seen[N_CH];
    int   rr_mode  = 0;
    int   mute_ch  = -1;
    int   ptr_m    = 0;
    bit   in_flight = 1'b0;
    int   cur_ch, cur_data, ack_cyc;
    int   err_cnt  = 0;
    int   last_val = 0;
    int   last_ch  = 0;
    exp_t exp_q[$];
    int   grant_log[$];
    int   exp_rr[8];

    always @(posedge ck) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int eng_func(input int x);
        return x * 447 / 1000;
    endfunction

    function automatic int rand_sample();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    // Grant rule: first requester at or after the pointer, wrapping; channel 0 wins outright in priority builds.
    function automatic int pick(input logic [N_CH-1:0] rv, input int p);
`ifdef FIR_SCHED_PRIORITY_EN
        if (rv[0]) return 0;
`endif
        for (int k = 0; k < N_CH; k++) begin
            int c;
            c = (p + k) % N_CH;
`ifdef FIR_SCHED_PRIORITY_EN
            if (c == 0) continue;
`endif
            if (rv[c]) return c;
        end
        return -1;
    endfunction

    function automatic int next_ptr(input int p, input int ch);
`ifdef FIR_SCHED_PRIORITY_EN
        if (ch == 0) return p;
`endif
        return (ch + 1) % N_CH;
    endfunction

    function automatic bit busy();
        bit b;
        b = in_flight || (exp_q.size() > 0);
        for (int c = 0; c < N_CH; c++) if (remaining[c] > 0) b = 1'b1;
        return b;
    endfunction

    // Producers and result consumer.
    initial begin : driver
        int rv_cnt;
        rv_cnt    = 0;
        req_valid = '0;
        req_data  = '0;
        res_ready = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            remaining[c] = 0;
            data_m[c]    = 0;
            ack_seen[c]  = 1'b0;
        end
        forever begin
            @(posedge ck);
            #1;
            for (int c = 0; c < N_CH; c++) begin
                if (ack_seen[c]) begin
                    ack_seen[c]  = 1'b0;
                    remaining[c] = remaining[c] - 1;
                    data_m[c]    = rand_sample();
                end
                req_valid[c]         = (remaining[c] > 0);
                req_data[c*W +: W]   = 16'(data_m[c]);
            end
            case (rr_mode)
                0: res_ready = 1'b1;
                1: res_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    rv_cnt    = res_valid ? rv_cnt + 1 : 0;
                    res_ready = (rv_cnt > 10);
                end
            endcase
        end
    end

    // Engine: completion pulse 18 cycles after start, result the cycle after.
    initial begin : engine
        int x, c;
        bit aborted;
        eng_output_ready = 1'b0;
        eng_out          = '0;
        forever begin
            @(negedge ck);
            if (eng_input_ready && !rst) begin
                x = int'($signed(eng_in));
                c = int'(eng_ch);
                if (c != mute_ch) begin
                    aborted = 1'b0;
                    for (int k = 0; k < 18; k++) begin
                        @(posedge ck);
                        if (rst) begin
                            aborted = 1'b1;
                            break;
                        end
                    end
                    if (!aborted) begin
                        #1 eng_output_ready = 1'b1;
                        @(posedge ck);
                        #1 eng_output_ready = 1'b0;
                        eng_out = 16'(eng_func(x));
                    end
                end
            end
        end
    end

    // Monitor: model bookkeeping and comparisons at the falling edge.
    initial begin : monitor
        exp_t e;
        int   g, actual;
        bit   prev_rv, prev_rr;
        int   prev_rd, prev_rc;
        prev_rv = 1'b0;
        prev_rr = 1'b0;
        prev_rd = 0;
        prev_rc = 0;
        forever begin
            @(negedge ck);
            if (rst) begin
                ptr_m     = 0;
                in_flight = 1'b0;
                exp_q.delete();
                prev_rv   = 1'b0;
                prev_rr   = 1'b0;
                continue;
            end
            if (err) begin
                err_cnt++;
                if (exp_q.size() == 0) begin
                    check("err_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("err_kind", int'(e.is_err), 1);
                    check("err_ch", int'(err_ch), e.ch);
                    check("err_time", cyc - ack_cyc, 65);
                end
                in_flight = 1'b0;
                ptr_m     = next_ptr(ptr_m, cur_ch);
            end
            if (eng_input_ready) begin
                check("issue_time", cyc - ack_cyc, 1);
                check("eng_in", int'($signed(eng_in)), cur_data);
                check("eng_ch", int'(eng_ch), cur_ch);
            end
            g = pick(req_valid, ptr_m);
            if (req_ack != '0) begin
                check("ack_while_busy", int'(in_flight), 0);
                check("ack_onehot", int'(req_ack), (g >= 0) ? (1 << g) : 0);
                actual = 0;
                for (int c = N_CH - 1; c >= 0; c--) if (req_ack[c]) actual = c;
                ack_seen[actual] = 1'b1;
                if (g >= 0) begin
                    e.is_err  = (g == mute_ch);
                    e.ch      = g;
                    e.val     = eng_func(data_m[g]);
                    exp_q.push_back(e);
                    in_flight = 1'b1;
                    cur_ch    = g;
                    cur_data  = data_m[g];
                    ack_cyc   = cyc;
                    grant_log.push_back(g);
                end
            end else if (!in_flight && g >= 0) begin
                check("ack_onehot", int'(req_ack), 1 << g);
            end
            if (res_valid) begin
                if (!prev_rv) begin
                    check("res_latency", cyc - ack_cyc, 21);
                end else if (!prev_rr) begin
                    check("hold_data", int'(res_data), prev_rd);
                    check("hold_ch", int'(res_ch), prev_rc);
                end
                if (res_ready) begin
                    if (exp_q.size() == 0) begin
                        check("res_unexpected", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("res_kind", int'(e.is_err), 0);
                        check("res_ch", int'(res_ch), e.ch);
                        check("res_data", int'($signed(res_data)), e.val);
                    end
                    last_val  = int'($signed(res_data));
                    last_ch   = int'(res_ch);
                    in_flight = 1'b0;
                    ptr_m     = next_ptr(ptr_m, cur_ch);
                end
            end
            prev_rv = res_valid;
            prev_rr = res_ready;
            prev_rd = int'(res_data);
            prev_rc = int'(res_ch);
        end
    end

    task automatic set_req(input int c, input int val, input int n);
        data_m[c]    = val;
        remaining[c] = n;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (busy() && n < budget) begin
            @(posedge ck);
            n++;
        end
        check({name, "_drained"}, int'(n < budget), 1);
    endtask

    task automatic do_reset();
        @(posedge ck);
        #2 rst = 1'b1;
        @(posedge ck);
        #2 rst = 1'b0;
        @(negedge ck);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_res_data"}, int'(res_data), 0);
        check({tag, "_eng_in"}, int'(eng_in), 0);
        check({tag, "_ctrl"}, int'({req_ack, eng_input_ready, eng_ch, res_ch, res_valid, err, err_ch}), 0);
    endtask

    task automatic check_log(input string name, input int n, input int exp[8]);
        check({name, "_count"}, grant_log.size(), n);
        for (int i = 0; i < n && i < grant_log.size(); i++) check({name, "_order"}, grant_log[i], exp[i]);
    endtask

    initial begin : main
        int n, sum;
        int two[8];
        rst = 1'b1;
        repeat (3) @(posedge ck);
        #2 rst = 1'b0;
        @(negedge ck);
        check_reset_outputs("reset");

        // Single channel: sample 1000 on channel 1.
        set_req(1, 1000, 1);
        wait_done("single", 200);
        check("single_val", last_val, 447);
        check("single_ch", last_ch, 1);

        // Round-robin with every channel requesting.
        do_reset();
        check_reset_outputs("rr_reset");
        grant_log.delete();
        rr_mode = 1;
        for (int c = 0; c < N_CH; c++) set_req(c, rand_sample(), 2);
`ifdef FIR_SCHED_PRIORITY_EN
        exp_rr = '{0, 0, 1, 2, 3, 1, 2, 3};
`else
        exp_rr = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
        wait_done("rr", 1500);
        check_log("rr", 8, exp_rr);

        // Backpressure: consumer stalls 10 cycles on each result.
        grant_log.delete();
        rr_mode = 2;
        set_req(0, rand_sample(), 1);
        set_req(2, rand_sample(), 1);
        wait_done("bp", 500);
        two = '{0, 2, 0, 0, 0, 0, 0, 0};
        check_log("bp", 2, two);

        // Timeout on channel 2 with channel 3 waiting behind it.
        rr_mode = 0;
        set_req(1, rand_sample(), 1);
        wait_done("pre_to", 200);
        mute_ch = 2;
        err_cnt = 0;
        grant_log.delete();
        set_req(2, rand_sample(), 1);
        set_req(3, rand_sample(), 1);
        wait_done("to", 500);
        mute_ch = -1;
        check("to_err_cnt", err_cnt, 1);
        two = '{2, 3, 0, 0, 0, 0, 0, 0};
        check_log("to", 2, two);

        // Reset while the engine is busy, then channels 0 and 3 together.
        set_req(3, rand_sample(), 1);
        n = 0;
        while (!(in_flight && cyc >= ack_cyc + 6) && n < 100) begin
            @(posedge ck);
            n++;
        end
        check("busy_reached", int'(n < 100), 1);
        do_reset();
        check_reset_outputs("mid_busy");
        grant_log.delete();
        set_req(0, rand_sample(), 1);
        set_req(3, rand_sample(), 1);
        wait_done("post_rst", 300);
        two = '{0, 3, 0, 0, 0, 0, 0, 0};
        check_log("post_rst", 2, two);

        // Random traffic.
        grant_log.delete();
        rr_mode = 1;
        sum = 0;
        for (int c = 0; c < N_CH; c++) begin
            n = int'($urandom_range(1, 3));
            sum += n;
            set_req(c, rand_sample(), n);
        end
        wait_done("rand", 3000);
        check("rand_count", grant_log.size(), sum);

`ifdef FIR_SCHED_PRIORITY_EN
        // Channel 0 starves channel 3 while it keeps requesting.
        grant_log.delete();
        rr_mode = 0;
        set_req(0, rand_sample(), 4);
        set_req(3, rand_sample(), 1);
        wait_done("prio", 800);
        two = '{0, 0, 0, 0, 3, 0, 0, 0};
        check_log("prio", 5, two);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

endmodule
